// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit with valid/ready issue and tag pass-through.
// Ports: clk, rst_n (async active-low), flush (sync kill of in-flight op);
//        in_valid/in_ready/in_op/in_a/in_b/in_tag request side (funct3 op encoding);
//        out_valid/out_ready/out_result/out_tag result side.
// Optional: define MULDIV_EARLY_OUT_EN to resolve divide special cases at accept (1-cycle latency).
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [2:0] S_IDLE = 3'd0, S_MUL = 3'd1, S_DIV = 3'd2, S_FIX = 3'd3, S_DONE = 3'd4;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Divide special cases; returns {hit, result}. Unsigned a<b matches the iterated result anyway.
    function automatic logic [XLEN:0] special(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic bz, ovf, ult;
        logic [XLEN-1:0] v;
        bz  = b == '0;
        ovf = !op[0] && a == MIN && b == '1;
        ult = op[0] && a < b;
        v   = bz ? (op[1] ? a : '1) : ovf ? (op[1] ? '0 : MIN) : (op[1] ? a : '0);
        return {bz | ovf | ult, v};
    endfunction

    logic [2:0]       st_q, st_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d, quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;

    logic accept;
    assign in_ready   = rst_n && st_q == S_IDLE;
    assign accept     = in_valid && in_ready && !flush;
    assign out_valid  = st_q == S_DONE;
    assign out_result = res_q;
    assign out_tag    = tag_q;

    // Multiplier reads the live inputs in IDLE so a single-stage build can finish on the accept edge.
    logic [1:0]        mop;
    logic [XLEN-1:0]   ma, mb, mul_res;
    logic              sa, sb;
    logic [2*XLEN-1:0] mpa, mpb, prod;
    assign mop     = st_q == S_IDLE ? in_op[1:0] : op_q;
    assign ma      = st_q == S_IDLE ? in_a : a_q;
    assign mb      = st_q == S_IDLE ? in_b : b_q;
    assign sa      = mop[1] ^ mop[0];
    assign sb      = mop == 2'b01;
    assign mpa     = {{XLEN{sa & ma[XLEN-1]}}, ma};
    assign mpb     = {{XLEN{sb & mb[XLEN-1]}}, mb};
    assign prod    = mpa * mpb;
    assign mul_res = mop == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    logic            na, nb, ge;
    logic [XLEN-1:0] mag_a, mag_b, fx_res;
    logic [XLEN:0]   sh, diff, fx_sp;
    assign na     = !in_op[0] && in_a[XLEN-1];
    assign nb     = !in_op[0] && in_b[XLEN-1];
    assign mag_a  = na ? -in_a : in_a;
    assign mag_b  = nb ? -in_b : in_b;
    // Restoring step: bring down the next dividend bit, subtract if it fits.
    assign sh     = {rem_q, quo_q[XLEN-1]};
    assign diff   = sh - {1'b0, dvs_q};
    assign ge     = !diff[XLEN];
    assign fx_sp  = special(op_q, a_q, b_q);
    assign fx_res = fx_sp[XLEN] ? fx_sp[XLEN-1:0] : op_q[1] ? (rneg_q ? -rem_q : rem_q) : (qneg_q ? -quo_q : quo_q);
`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN:0] in_sp;
    assign in_sp = special(in_op[1:0], in_a, in_b);
`endif

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        tag_d  = tag_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        res_d  = res_q;
        case (st_q)
            S_IDLE: if (accept) begin
                op_d  = in_op[1:0];
                a_d   = in_a;
                b_d   = in_b;
                tag_d = in_tag;
                if (!in_op[2]) begin
                    if (MUL_STAGES == 1) begin
                        st_d  = S_DONE;
                        res_d = mul_res;
                    end else begin
                        st_d  = S_MUL;
                        cnt_d = 6'(MUL_STAGES - 2);
                    end
                end else begin
                    st_d   = S_DIV;
                    cnt_d  = 6'(XLEN - 1);
                    quo_d  = mag_a;
                    rem_d  = '0;
                    dvs_d  = mag_b;
                    qneg_d = na ^ nb;
                    rneg_d = na;
`ifdef MULDIV_EARLY_OUT_EN
                    if (in_sp[XLEN]) begin
                        st_d  = S_DONE;
                        res_d = in_sp[XLEN-1:0];
                    end
`endif
                end
            end
            S_MUL: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == '0) begin
                    st_d  = S_DONE;
                    res_d = mul_res;
                end
            end
            S_DIV: begin
                cnt_d = cnt_q - 6'd1;
                quo_d = {quo_q[XLEN-2:0], ge};
                rem_d = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
                st_d  = cnt_q == '0 ? S_FIX : S_DIV;
            end
            S_FIX: begin
                st_d  = S_DONE;
                res_d = fx_res;
            end
            S_DONE: st_d = out_ready ? S_IDLE : S_DONE;
            default: st_d = S_IDLE;
        endcase
        if (flush) st_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= S_IDLE;
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            tag_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            res_q  <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            tag_q  <= tag_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            res_q  <= res_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit; directed vectors, decoupled monitor checks result, tag and latency.
module tb_muldiv_unit;
    localparam int MS = 2;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int ELAT = 1;
`else
    localparam int ELAT = 34;
`endif
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [2:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic [4:0]  in_tag = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int   tests = 0, fails = 0, cyc = 0;
    exp_t sb[$];
    exp_t e;
    bit   seen = 1'b0;
    logic [31:0] hr;
    logic [4:0]  ht;

    muldiv_unit #(.XLEN(32), .MUL_STAGES(MS), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] res, input int lat, input bit push);
        int w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("issue_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        if (push) sb.push_back('{res, tag, cyc, lat});
        @(negedge clk);
        in_valid = 1'b0;
        chk("accepted", 32'(in_ready), 32'd0);
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((sb.size() != 0 || out_valid) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(sb.size() == 0 && !out_valid), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst_n) seen = 1'b0;
        else if (out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                hr   = out_result;
                ht   = out_tag;
                if (sb.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("result", out_result, e.res);
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end else begin
                chk("hold_result", out_result, hr);
                chk("hold_tag", 32'(out_tag), 32'(ht));
            end
        end else seen = 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);

        issue(MULH,   32'h80000000, 32'h80000000, 5'd3,  32'h40000000, MS, 1'b1);
        issue(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, MS, 1'b1);
        issue(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, MS, 1'b1);
        issue(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000001, MS, 1'b1);
        issue(MULH,   32'd3,        32'hFFFFFFFE, 5'd7,  32'hFFFFFFFF, MS, 1'b1);
        issue(MUL,    32'h12345678, 32'h10,       5'd8,  32'h23456780, MS, 1'b1);
        issue(DIV,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 34, 1'b1);
        issue(REM,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 34, 1'b1);
        issue(DIV,    32'd7,        32'hFFFFFFFE, 5'd11, 32'hFFFFFFFD, 34, 1'b1);
        issue(REM,    32'd7,        32'hFFFFFFFE, 5'd12, 32'd1,        34, 1'b1);
        issue(DIVU,   32'd100,      32'd7,        5'd13, 32'd14,       34, 1'b1);
        issue(REMU,   32'd100,      32'd7,        5'd14, 32'd2,        34, 1'b1);
        issue(DIVU,   32'd100,      32'd0,        5'd15, 32'hFFFFFFFF, ELAT, 1'b1);
        issue(REM,    32'd100,      32'd0,        5'd16, 32'd100,      ELAT, 1'b1);
        issue(REM,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        ELAT, 1'b1);
        issue(DIV,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, ELAT, 1'b1);
        issue(DIVU,   32'd5,        32'd9,        5'd19, 32'd0,        ELAT, 1'b1);
        issue(REMU,   32'd5,        32'd9,        5'd20, 32'd5,        ELAT, 1'b1);
        wait_drain();

        out_ready = 1'b0;
        issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21, 32'hFFFFFFFE, MS, 1'b1);
        for (int w = 0; w < 100 && !out_valid; w++) @(negedge clk);
        chk("hold_wait", 32'(out_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("retire_valid", 32'(out_valid), 32'd0);
        chk("retire_ready", 32'(in_ready), 32'd1);
        issue(MUL, 32'h12345678, 32'h10, 5'd22, 32'h23456780, MS, 1'b1);
        wait_drain();

        issue(DIV, 32'd1000, 32'd3, 5'd23, 32'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = MUL;
        in_a     = 32'd5;
        in_b     = 32'd6;
        in_tag   = 5'd24;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);
        chk("flush_idle", 32'(in_ready), 32'd1);

        issue(MUL, 32'd3, 32'd5, 5'd25, 32'd15, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_result", out_result, 32'd0);
        chk("arst_tag", 32'(out_tag), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_ready_after", 32'(in_ready), 32'd1);
        chk("arst_no_out", 32'(out_valid), 32'd0);
        issue(MULHU, 32'd2, 32'd3, 5'd26, 32'd0, MS, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
